// File: rtl/mips_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control.
package mips_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A write to r0 never produces a dependency.
    function automatic logic reg_hit(input logic [4:0] dest, input logic [4:0] src);
        return (dest != REG_ZERO) && (dest == src);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Counts the EX occupancy of a multi-cycle mul/div op; the start cycle itself is not counted.
module md_busy_timer #(
    parameter int MD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CNT_BITS = $clog2(MD_CYCLES + 1);

    logic [CNT_BITS-1:0] md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_BITS'(1);
        end else if (start) begin
            md_cnt <= CNT_BITS'(MD_CYCLES - 1);
        end
    end

    assign busy = (md_cnt != '0);
    assign done = (md_cnt == CNT_BITS'(1));

    // A second op cannot issue while EX is still held by the first one.
    assert property (@(posedge clk) disable iff (reset) !(start && busy))
        else $error("md_busy_timer: md start while busy ignored");

endmodule

// File: rtl/hazard_unit.sv
// Bypass selects, load-use/branch hazard detection, mul/div freeze and stall-cycle counter.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             branch_ID,
    input  logic             pcsrc_ID,
    input  logic [4:0]       rs_EX,
    input  logic [4:0]       rt_EX,
    input  logic [4:0]       writereg_EX,
    input  logic             regwrite_EX,
    input  logic             memtoreg_EX,
    input  logic             md_start_EX,
    input  logic [4:0]       writereg_MEM,
    input  logic             regwrite_MEM,
    input  logic             memtoreg_MEM,
    input  logic [4:0]       writereg_WB,
    input  logic             regwrite_WB,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             forward_a_ID,
    output logic             forward_b_ID,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic             flush_MEM,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_count
);

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;
    logic     lwstall;
    logic     brstall;
    logic     stall;

    md_busy_timer #(.MD_CYCLES(MD_CYCLES)) u_md_timer (
        .clk   (clk),
        .reset (reset),
        .start (md_start_EX),
        .busy  (md_busy),
        .done  (md_done)
    );

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        // MEM holds the younger result, so it takes priority over WB.
        if (regwrite_MEM && reg_hit(writereg_MEM, rs_EX))
            fwd_a = FWD_MEM;
        else if (regwrite_WB && reg_hit(writereg_WB, rs_EX))
            fwd_a = FWD_WB;
        if (regwrite_MEM && reg_hit(writereg_MEM, rt_EX))
            fwd_b = FWD_MEM;
        else if (regwrite_WB && reg_hit(writereg_WB, rt_EX))
            fwd_b = FWD_WB;
    end

    assign forward_a    = fwd_a;
    assign forward_b    = fwd_b;
    assign forward_a_ID = regwrite_MEM && reg_hit(writereg_MEM, rs_ID);
    assign forward_b_ID = regwrite_MEM && reg_hit(writereg_MEM, rt_ID);

    always_comb begin
        lwstall = memtoreg_EX &&
                  (reg_hit(writereg_EX, rs_ID) || reg_hit(writereg_EX, rt_ID));
        // ID-stage compare cannot take an EX result or a load still in MEM.
        brstall = branch_ID &&
                  ((regwrite_EX && (reg_hit(writereg_EX, rs_ID) || reg_hit(writereg_EX, rt_ID))) ||
                   (memtoreg_MEM && (reg_hit(writereg_MEM, rs_ID) || reg_hit(writereg_MEM, rt_ID))));
        stall   = lwstall || brstall || md_busy;
    end

    assign stall_IF  = stall;
    assign stall_ID  = stall;
    assign stall_EX  = md_busy;
    assign flush_MEM = md_busy;
    assign flush_EX  = (lwstall || brstall) && !md_busy;
    assign flush_ID  = pcsrc_ID && !stall;

    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a cycle-indexed reference model.
module tb_hazard_unit;

    localparam int MD = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs_ID, rt_ID, rs_EX, rt_EX, writereg_EX, writereg_MEM, writereg_WB;
    logic          branch_ID, pcsrc_ID, regwrite_EX, memtoreg_EX, md_start_EX;
    logic          regwrite_MEM, memtoreg_MEM, regwrite_WB;
    logic [1:0]    forward_a, forward_b;
    logic          forward_a_ID, forward_b_ID, stall_IF, stall_ID, stall_EX;
    logic          flush_ID, flush_EX, flush_MEM, md_busy, md_done;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    int cyc;
    int md_last;
    int cnt_m;

    always #5 clk = ~clk;

    hazard_unit #(.MD_CYCLES(MD), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .branch_ID(branch_ID), .pcsrc_ID(pcsrc_ID),
        .rs_EX(rs_EX), .rt_EX(rt_EX), .writereg_EX(writereg_EX),
        .regwrite_EX(regwrite_EX), .memtoreg_EX(memtoreg_EX), .md_start_EX(md_start_EX),
        .writereg_MEM(writereg_MEM), .regwrite_MEM(regwrite_MEM), .memtoreg_MEM(memtoreg_MEM),
        .writereg_WB(writereg_WB), .regwrite_WB(regwrite_WB),
        .forward_a(forward_a), .forward_b(forward_b),
        .forward_a_ID(forward_a_ID), .forward_b_ID(forward_b_ID),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
        .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM),
        .md_busy(md_busy), .md_done(md_done), .stall_count(stall_count)
    );

    function automatic logic hit(input logic [4:0] w, input logic [4:0] r);
        return (w != 5'd0) && (w == r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 0; rs_ID = 0; rt_ID = 0; branch_ID = 0; pcsrc_ID = 0;
        rs_EX = 0; rt_EX = 0; writereg_EX = 0; regwrite_EX = 0; memtoreg_EX = 0;
        md_start_EX = 0; writereg_MEM = 0; regwrite_MEM = 0; memtoreg_MEM = 0;
        writereg_WB = 0; regwrite_WB = 0;
    endtask

    // Check every output against the model for the current cycle, then advance one clock.
    task automatic step();
        logic lw, br, busy, done, stall;
        logic [1:0] fa, fb;
        #1;
        busy  = (cyc <= md_last);
        done  = (cyc == md_last);
        lw    = memtoreg_EX && (hit(writereg_EX, rs_ID) || hit(writereg_EX, rt_ID));
        br    = branch_ID &&
                ((regwrite_EX && (hit(writereg_EX, rs_ID) || hit(writereg_EX, rt_ID))) ||
                 (memtoreg_MEM && (hit(writereg_MEM, rs_ID) || hit(writereg_MEM, rt_ID))));
        stall = lw || br || busy;
        fa = (regwrite_MEM && hit(writereg_MEM, rs_EX)) ? 2'b10 :
             (regwrite_WB  && hit(writereg_WB,  rs_EX)) ? 2'b01 : 2'b00;
        fb = (regwrite_MEM && hit(writereg_MEM, rt_EX)) ? 2'b10 :
             (regwrite_WB  && hit(writereg_WB,  rt_EX)) ? 2'b01 : 2'b00;
        chk("forward_a", 32'(forward_a), 32'(fa));
        chk("forward_b", 32'(forward_b), 32'(fb));
        chk("forward_a_ID", 32'(forward_a_ID), 32'(regwrite_MEM && hit(writereg_MEM, rs_ID)));
        chk("forward_b_ID", 32'(forward_b_ID), 32'(regwrite_MEM && hit(writereg_MEM, rt_ID)));
        chk("stall_IF", 32'(stall_IF), 32'(stall));
        chk("stall_ID", 32'(stall_ID), 32'(stall));
        chk("stall_EX", 32'(stall_EX), 32'(busy));
        chk("flush_MEM", 32'(flush_MEM), 32'(busy));
        chk("flush_EX", 32'(flush_EX), 32'((lw || br) && !busy));
        chk("flush_ID", 32'(flush_ID), 32'(pcsrc_ID && !stall));
        chk("md_busy", 32'(md_busy), 32'(busy));
        chk("md_done", 32'(md_done), 32'(done));
        chk("stall_count", 32'(stall_count), 32'(cnt_m));
        @(posedge clk);
        if (reset) begin
            md_last = -1;
            cnt_m   = 0;
        end else begin
            if (md_start_EX && !busy) md_last = cyc + MD - 1;
            if (stall && cnt_m < CNT_MAX) cnt_m++;
        end
        cyc++;
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        cyc = 0; md_last = -1; cnt_m = 0;
        step();                                   // reset still high: state must be zero
        reset = 0;
        chk("reset_busy", 32'(md_busy), 32'd0);
        chk("reset_count", 32'(stall_count), 32'd0);

        // 1. MEM beats WB; r0 in MEM falls back to WB
        regwrite_MEM = 1; writereg_MEM = 5; regwrite_WB = 1; writereg_WB = 5; rs_EX = 5;
        #1 chk("t1_fwd_mem", 32'(forward_a), 32'h2);
        step();
        writereg_MEM = 0;
        #1 chk("t1_fwd_wb", 32'(forward_a), 32'h1);
        step();

        // 2. load-use
        clear_inputs();
        memtoreg_EX = 1; writereg_EX = 8; rt_ID = 8;
        #1 chk("t2_stall", 32'({stall_IF, stall_ID, flush_EX}), 32'h7);
        step();
        chk("t2_count", 32'(stall_count), 32'd1);

        // 3. branch compare vs EX producer, then MEM forward
        clear_inputs();
        branch_ID = 1; regwrite_EX = 1; writereg_EX = 3; rs_ID = 3;
        #1 chk("t3_brstall", 32'(stall_ID), 32'd1);
        step();
        regwrite_EX = 0; writereg_EX = 0; regwrite_MEM = 1; writereg_MEM = 3;
        #1 chk("t3_fwd_id", 32'({forward_a_ID, stall_ID}), 32'h2);
        step();

        // 4. mul/div occupancy
        clear_inputs();
        md_start_EX = 1;
        step();
        md_start_EX = 0;
        for (int i = 0; i < MD - 1; i++) begin
            #1 chk("t4_busy", 32'({md_busy, stall_EX, flush_MEM}), 32'h7);
            chk("t4_done", 32'(md_done), 32'(i == MD - 2));
            step();
        end
        chk("t4_idle", 32'(md_busy), 32'd0);

        // 5. reset in second busy cycle aborts op
        md_start_EX = 1;
        step();
        md_start_EX = 0;
        step();
        reset = 1;
        step();
        reset = 0;
        #1 chk("t5_abort", 32'({md_busy, md_done}), 32'd0);
        chk("t5_count", 32'(stall_count), 32'd0);
        step();

        // 6. branch-taken flush, suppressed by load-use stall
        clear_inputs();
        pcsrc_ID = 1;
        #1 chk("t6_flush", 32'(flush_ID), 32'd1);
        step();
        memtoreg_EX = 1; writereg_EX = 9; rs_ID = 9;
        #1 chk("t6_noflush", 32'(flush_ID), 32'd0);
        step();

        // stall counter saturation
        for (int i = 0; i < CNT_MAX + 4; i++) step();
        chk("sat_count", 32'(stall_count), 32'(CNT_MAX));

        // randomized traffic
        reset = 1;
        step();
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 60) == 0);
            rs_ID        = 5'($urandom_range(0, 7));
            rt_ID        = 5'($urandom_range(0, 7));
            rs_EX        = 5'($urandom_range(0, 7));
            rt_EX        = 5'($urandom_range(0, 7));
            writereg_EX  = 5'($urandom_range(0, 7));
            writereg_MEM = 5'($urandom_range(0, 7));
            writereg_WB  = 5'($urandom_range(0, 7));
            branch_ID    = 1'($urandom_range(0, 1));
            pcsrc_ID     = 1'($urandom_range(0, 1));
            regwrite_EX  = 1'($urandom_range(0, 1));
            memtoreg_EX  = ($urandom_range(0, 3) == 0);
            regwrite_MEM = 1'($urandom_range(0, 1));
            memtoreg_MEM = ($urandom_range(0, 3) == 0);
            regwrite_WB  = 1'($urandom_range(0, 1));
            md_start_EX  = (cyc > md_last) && ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
